// File: rtl/med_pkg.sv
// Shared types and default constants for the Manchester encoder/decoder host bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package med_pkg;

    localparam int MED_FIFO_DEPTH    = 8;
    localparam int MED_STROBE_CYCLES = 2;
    localparam int MED_ACK_TIMEOUT   = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_STROBE,
        TX_WAIT_ACK,
        TX_WAIT_EMPTY
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_STROBE,
        RX_WAIT_CLR
    } rx_state_t;

endpackage

// File: rtl/med_fifo.sv
// Synchronous first-word-fall-through FIFO, WIDTH bits by DEPTH entries (DEPTH a power of 2).
// Latency: a pushed word appears on pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; push and pop together both succeed.
// Ports: clk/rst (sync, active high), push/push_dat write side, pop/pop_dat read side, full/empty status.
module med_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/med_host_bridge.sv
// Host byte stream bridge to a Manchester encoder (write strobe) and decoder (read strobe).
// Latency: TX byte reaches med_din one cycle after pop, strobe follows; RX byte visible the cycle after capture.
// Backpressure: tx_ready drops when TX FIFO full; a decoder byte arriving into a full RX FIFO is dropped and flags rx_overrun.
// Ports: clk16x/rst, host tx_*/rx_* valid-ready, encoder med_din/med_wrn/med_tbre, decoder med_dout/med_data_ready/med_rdn, sticky flags + clr_flags.
module med_host_bridge
    import med_pkg::*;
#(
    parameter int FIFO_DEPTH    = MED_FIFO_DEPTH,
    parameter int STROBE_CYCLES = MED_STROBE_CYCLES,
    parameter int ACK_TIMEOUT   = MED_ACK_TIMEOUT
) (
    input  logic       clk16x,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] med_din,
    output logic       med_wrn,
    input  logic       med_tbre,
    input  logic [7:0] med_dout,
    input  logic       med_data_ready,
    output logic       med_rdn,
    output logic       rx_overrun,
    output logic       tx_timeout,
    input  logic       clr_flags
);
    localparam int CNT_MAX = (ACK_TIMEOUT > STROBE_CYCLES) ? ACK_TIMEOUT : STROBE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

    // ---------------- FIFOs ----------------
    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full, rx_empty;

    med_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk16x),
        .rst      (rst),
        .push     (tx_valid),
        .push_dat (tx_data),
        .pop      (tx_pop),
        .pop_dat  (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    med_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk16x),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (med_dout),
        .pop      (rx_ready),
        .pop_dat  (rx_data),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic             tx_to_set;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_to_set    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && med_tbre) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_SETUP;
                end
            end
            TX_SETUP:  tx_state_nxt = TX_STROBE;
            TX_STROBE: if (tx_cnt == STROBE_LAST) tx_state_nxt = TX_WAIT_ACK;
            TX_WAIT_ACK: begin
                if (!med_tbre) begin
                    tx_state_nxt = TX_WAIT_EMPTY;
                end else if (tx_cnt == ACK_LAST) begin
                    tx_to_set    = 1'b1;   // encoder never took the byte; give up on it
                    tx_state_nxt = TX_IDLE;
                end
            end
            TX_WAIT_EMPTY: if (med_tbre) tx_state_nxt = TX_IDLE;
            default:   tx_state_nxt = TX_IDLE;
        endcase
    end

    // med_wrn is registered from the next state so the strobe is glitch-free and
    // releases on the edge right after reset.
    always_ff @(posedge clk16x) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            med_din  <= 8'h00;
            med_wrn  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state_nxt == tx_state && (tx_state == TX_STROBE || tx_state == TX_WAIT_ACK))
                tx_cnt <= tx_cnt + 1'b1;
            else
                tx_cnt <= '0;
            if (tx_pop) med_din <= tx_head;
            med_wrn <= (tx_state_nxt != TX_STROBE);
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic             rx_ovr_set;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_push      = 1'b0;
        rx_ovr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (med_data_ready) begin
                    rx_push      = !rx_full;
                    rx_ovr_set   = rx_full;
                    rx_state_nxt = RX_STROBE;
                end
            end
            RX_STROBE: if (rx_cnt == STROBE_LAST) rx_state_nxt = RX_WAIT_CLR;
            // Holding here until data_ready drops keeps one byte from being captured twice.
            RX_WAIT_CLR: if (!med_data_ready) rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk16x) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            med_rdn  <= 1'b1;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state_nxt == rx_state && rx_state == RX_STROBE)
                rx_cnt <= rx_cnt + 1'b1;
            else
                rx_cnt <= '0;
            med_rdn <= (rx_state_nxt != RX_STROBE);
        end
    end

    // ---------------- Sticky flags: a set event beats a same-cycle clear ----------------
    always_ff @(posedge clk16x) begin
        if (rst) begin
            tx_timeout <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (tx_to_set)      tx_timeout <= 1'b1;
            else if (clr_flags) tx_timeout <= 1'b0;
            if (rx_ovr_set)     rx_overrun <= 1'b1;
            else if (clr_flags) rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_med_host_bridge.sv
// Self-checking bench for med_host_bridge: directed scenarios plus a randomized concurrent phase.
// Encoder/decoder behaviour and a queue-based reference model run inside the step task.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_med_host_bridge;
    localparam int DEPTH   = 8;
    localparam int STROBE  = 2;
    localparam int TIMEOUT = 16;

    logic       clk16x = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] med_din;
    logic       med_wrn;
    logic       med_tbre = 1'b1;
    logic [7:0] med_dout = 8'h00;
    logic       med_data_ready = 1'b0;
    logic       med_rdn;
    logic       rx_overrun;
    logic       tx_timeout;
    logic       clr_flags = 1'b0;

    always #5 clk16x = ~clk16x;

    med_host_bridge #(.FIFO_DEPTH(DEPTH), .STROBE_CYCLES(STROBE), .ACK_TIMEOUT(TIMEOUT)) dut (
        .clk16x(clk16x), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .med_din(med_din), .med_wrn(med_wrn), .med_tbre(med_tbre),
        .med_dout(med_dout), .med_data_ready(med_data_ready), .med_rdn(med_rdn),
        .rx_overrun(rx_overrun), .tx_timeout(tx_timeout), .clr_flags(clr_flags)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] tx_exp[$];     // bytes the host successfully pushed, in order
    logic [7:0] wr_bytes[$];   // bytes seen on med_din at each med_wrn fall
    int         wr_pulses[$];  // med_wrn low widths
    int         rd_pulses[$];  // med_rdn low widths
    logic [7:0] rx_mq[$];      // expected RX FIFO contents
    logic [7:0] dec_q[$];      // bytes waiting to be offered by the decoder
    logic       model_ovr = 1'b0;
    int         wr_run = 0, rd_run = 0, wr_rises = 0, n_pops = 0;
    logic       wrn_prev = 1'b1, rdn_prev = 1'b1;
    logic [7:0] din_prev = 8'h00;
    int         enc_mode = 2;  // 0: tbre stuck 0, 1: tbre stuck 1, 2: acknowledging encoder
    int         enc_delay = 0, enc_busy = 0;
    logic       dec_active = 1'b0;
    int         dec_gap = 0;
    logic [7:0] dec_cur = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_enc(input int mode);
        enc_mode  = mode;
        enc_delay = 0;
        enc_busy  = 0;
    endtask

    // One clock: capture pre-edge handshakes, advance, update model, monitors and external devices.
    task automatic step();
        logic       pre_rst, pre_clr, pre_acc, pre_pop, ovf;
        logic [7:0] pre_tdat, pre_rdat, head;
        pre_rst  = rst;
        pre_clr  = clr_flags;
        pre_acc  = tx_valid && tx_ready;
        pre_tdat = tx_data;
        pre_pop  = rx_valid && rx_ready;
        pre_rdat = rx_data;
        @(posedge clk16x);
        #1;
        if (pre_rst) begin
            rx_mq.delete();
            model_ovr = 1'b0;
        end else begin
            if (pre_acc) tx_exp.push_back(pre_tdat);
            ovf = 1'b0;
            if (rdn_prev && !med_rdn) begin
                if (rx_mq.size() < DEPTH) rx_mq.push_back(dec_cur);
                else ovf = 1'b1;
            end
            if (ovf) model_ovr = 1'b1;
            else if (pre_clr) model_ovr = 1'b0;
            if (pre_pop) begin
                n_pops++;
                check("rx_pop_nonempty", 32'(rx_mq.size() != 0), 32'd1);
                if (rx_mq.size() != 0) begin
                    head = rx_mq.pop_front();
                    check("rx_pop_data", 32'(pre_rdat), 32'(head));
                end
            end
            check("rx_valid_model", 32'(rx_valid), 32'(rx_mq.size() != 0));
            check("rx_overrun_model", 32'(rx_overrun), 32'(model_ovr));
        end
        // write strobe monitor
        if (!med_wrn) wr_run++;
        if (wrn_prev && !med_wrn) begin
            wr_bytes.push_back(med_din);
            check("din_setup", 32'(med_din), 32'(din_prev));
        end
        if (!wrn_prev && !med_wrn) check("din_hold", 32'(med_din), 32'(din_prev));
        if (!wrn_prev && med_wrn) begin
            wr_pulses.push_back(wr_run);
            wr_run = 0;
            wr_rises++;
        end
        // read strobe monitor
        if (!med_rdn) rd_run++;
        if (!rdn_prev && med_rdn) begin
            rd_pulses.push_back(rd_run);
            rd_run = 0;
        end
        // encoder
        case (enc_mode)
            0: med_tbre = 1'b0;
            1: med_tbre = 1'b1;
            default: begin
                if (enc_delay > 0) begin
                    enc_delay--;
                    if (enc_delay == 0) enc_busy = 4;
                end else if (enc_busy > 0) begin
                    enc_busy--;
                end
                if (!wrn_prev && med_wrn) enc_delay = 3;
                med_tbre = (enc_busy == 0);
            end
        endcase
        // decoder: clears data_ready when it sees the read strobe
        if (rdn_prev && !med_rdn) begin
            med_data_ready = 1'b0;
            dec_active     = 1'b0;
            dec_gap        = 3;
        end else if (!dec_active) begin
            if (dec_gap > 0) dec_gap--;
            else if (dec_q.size() != 0) begin
                dec_cur        = dec_q.pop_front();
                med_dout       = dec_cur;
                med_data_ready = 1'b1;
                dec_active     = 1'b1;
            end
        end
        wrn_prev = med_wrn;
        rdn_prev = med_rdn;
        din_prev = med_din;
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_count"}, 32'(wr_bytes.size()), 32'(tx_exp.size()));
        for (int i = 0; i < wr_bytes.size() && i < tx_exp.size(); i++)
            check({tag, "_byte"}, 32'(wr_bytes[i]), 32'(tx_exp[i]));
        foreach (wr_pulses[i]) check({tag, "_wrn_width"}, 32'(wr_pulses[i]), STROBE);
        tx_exp.delete();
        wr_bytes.delete();
        wr_pulses.delete();
    endtask

    task automatic push_one(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        int r0;
        int wr0;
        logic acc;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) step();
        check("rst_wrn", 32'(med_wrn), 32'd1);
        check("rst_rdn", 32'(med_rdn), 32'd1);
        check("rst_din", 32'(med_din), 32'h00);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_timeout", 32'(tx_timeout), 32'd0);
        rst = 1'b0;
        step();

        // ---- single write 0xA5 with acknowledging encoder ----
        push_one(8'hA5);
        repeat (30) step();
        check("a5_writes", 32'(wr_bytes.size()), 32'd1);
        check("a5_timeout", 32'(tx_timeout), 32'd0);
        compare_tx("a5");

        // ---- back-to-back pushes with tbre stuck low ----
        set_enc(0);
        step();
        for (int v = 1; v <= 9; v++) begin
            tx_data  = 8'(v);
            tx_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                acc = tx_ready;
                step();
                if (acc) break;
            end
        end
        tx_valid = 1'b0;
        check("fill_accepted", 32'(tx_exp.size()), DEPTH);
        check("fill_tx_ready", 32'(tx_ready), 32'd0);
        check("fill_no_writes", 32'(wr_bytes.size()), 32'd0);
        check("fill_wrn_idle", 32'(med_wrn), 32'd1);
        set_enc(2);
        for (int k = 0; k < 400 && wr_bytes.size() < DEPTH; k++) step();
        repeat (20) step();
        compare_tx("fill_drain");

        // ---- ack timeout with tbre stuck high; then set beats clear ----
        set_enc(1);
        step();
        r0 = wr_rises;
        push_one(8'h5A);
        for (int k = 0; k < 20 && wr_rises == r0; k++) step();
        check("to_strobe_seen", 32'(wr_rises - r0), 32'd1);
        repeat (TIMEOUT - 1) step();
        check("to_early", 32'(tx_timeout), 32'd0);
        step();
        check("to_set", 32'(tx_timeout), 32'd1);
        wr0 = wr_bytes.size();
        repeat (5) step();
        check("to_idle_no_retry", 32'(wr_bytes.size()), 32'(wr0));
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("to_clear", 32'(tx_timeout), 32'd0);
        r0 = wr_rises;
        push_one(8'h66);
        for (int k = 0; k < 20 && wr_rises == r0; k++) step();
        repeat (TIMEOUT - 1) step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("to_set_wins", 32'(tx_timeout), 32'd1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("to_clear2", 32'(tx_timeout), 32'd0);
        compare_tx("to");
        set_enc(2);
        step();

        // ---- single receive 0x3C ----
        rx_ready = 1'b0;
        dec_q.push_back(8'h3C);
        for (int k = 0; k < 30 && rd_pulses.size() == 0; k++) step();
        repeat (5) step();
        check("rx1_valid", 32'(rx_valid), 32'd1);
        check("rx1_data", 32'(rx_data), 32'h3C);
        check("rx1_pulses", 32'(rd_pulses.size()), 32'd1);
        if (rd_pulses.size() != 0) check("rx1_rdn_width", 32'(rd_pulses[0]), STROBE);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("rx1_popped", 32'(rx_valid), 32'd0);
        rd_pulses.delete();

        // ---- nine receives with host stalled: overrun ----
        for (int i = 0; i < 9; i++) dec_q.push_back(8'($urandom_range(0, 255)));
        for (int k = 0; k < 300 && rd_pulses.size() < 9; k++) step();
        repeat (10) step();
        check("ovr_pulses", 32'(rd_pulses.size()), 32'd9);
        foreach (rd_pulses[i]) check("ovr_rdn_width", 32'(rd_pulses[i]), STROBE);
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        n_pops   = 0;
        rx_ready = 1'b1;
        for (int k = 0; k < 40 && rx_valid; k++) step();
        rx_ready = 1'b0;
        check("ovr_pops", 32'(n_pops), DEPTH);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("ovr_clear", 32'(rx_overrun), 32'd0);
        rd_pulses.delete();

        // ---- randomized concurrent TX and RX ----
        for (int c = 0; c < 500; c++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom_range(0, 255));
            rx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dec_q.push_back(8'($urandom_range(0, 255)));
            step();
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        for (int k = 0; k < 3000 && !(dec_q.size() == 0 && !dec_active && rx_mq.size() == 0
                                      && wr_bytes.size() == tx_exp.size() && enc_busy == 0
                                      && enc_delay == 0 && med_wrn); k++)
            step();
        repeat (20) step();
        compare_tx("rand");
        foreach (rd_pulses[i]) check("rand_rdn_width", 32'(rd_pulses[i]), STROBE);
        check("rand_rx_drained", 32'(rx_mq.size()), 32'd0);
        check("rand_timeout", 32'(tx_timeout), 32'd0);
        rx_ready = 1'b0;
        rd_pulses.delete();

        // ---- reset while med_wrn is low ----
        set_enc(1);
        step();
        push_one(8'h11);
        push_one(8'h22);
        push_one(8'h33);
        for (int k = 0; k < 20 && med_wrn; k++) step();
        check("mid_wrn_low", 32'(med_wrn), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_wrn", 32'(med_wrn), 32'd1);
        check("mid_rdn", 32'(med_rdn), 32'd1);
        check("mid_din", 32'(med_din), 32'h00);
        check("mid_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_timeout", 32'(tx_timeout), 32'd0);
        check("mid_overrun", 32'(rx_overrun), 32'd0);
        tx_exp.delete();
        wr_bytes.delete();
        wr_pulses.delete();
        repeat (10) step();
        check("mid_fifo_flushed", 32'(wr_bytes.size()), 32'd0);
        check("mid_wrn_idle", 32'(med_wrn), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
